// File: rtl/pitch_scan_ctrl.sv
// Pitch-table sequencer: walks every voice/osc slot through the shared pitch datapath,
// waits out the pipeline latency and captures each result; note requests jump the queue.
module pitch_scan_ctrl #(
   parameter int VOICES   = 8,
   parameter int V_OSC    = 4,
   parameter int V_WIDTH  = 3,
   parameter int O_WIDTH  = 2,
   parameter int OE_WIDTH = 1,
   parameter int LAT      = 3,
   parameter int PW       = 24
) (
   input  logic                                  const_clk,
   input  logic                                  reset,
   input  logic                                  enable,
   input  logic                                  note_req,
   input  logic [V_WIDTH-1:0]                    note_voice,
   input  logic                                  cfg_write,
   input  logic [PW-1:0]                         pitch_in,
   output logic [V_WIDTH+O_WIDTH+OE_WIDTH-1:0]   xxxx,
   input  logic [V_WIDTH-1:0]                    rd_voice,
   input  logic [O_WIDTH-1:0]                    rd_osc,
   output logic [PW-1:0]                         rd_pitch,
   output logic                                  busy,
   output logic                                  scan_done,
   output logic                                  req_drop
);

   localparam logic [V_WIDTH-1:0] V_LAST = V_WIDTH'(VOICES - 1);
   localparam logic [O_WIDTH-1:0] O_LAST = O_WIDTH'(V_OSC - 1);
   localparam int                 CW     = (LAT > 1) ? $clog2(LAT) : 1;
   localparam logic [CW-1:0]      C_LOAD = CW'(LAT - 1);

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPT} state_t;

   state_t               r_state, w_state_nx;
   logic [CW-1:0]        r_cnt, w_cnt_nx;
   logic [V_WIDTH-1:0]   r_voice, w_voice_nx;
   logic [O_WIDTH-1:0]   r_osc, w_osc_nx;
   logic                 r_cur_pri, w_cur_pri_nx;
   logic [V_WIDTH-1:0]   r_bg_voice, w_bg_voice_nx;
   logic [O_WIDTH-1:0]   r_bg_osc, w_bg_osc_nx;
   logic                 r_pend_valid;
   logic [V_WIDTH-1:0]   r_pend_voice;
   logic                 r_scan_done, r_req_drop;
   logic                 w_consume, w_capt, w_wrap;
   logic [PW-1:0]        r_table [VOICES][V_OSC];

   always_ff @(posedge const_clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx    = r_state;
      w_cnt_nx      = r_cnt;
      w_voice_nx    = r_voice;
      w_osc_nx      = r_osc;
      w_cur_pri_nx  = r_cur_pri;
      w_bg_voice_nx = r_bg_voice;
      w_bg_osc_nx   = r_bg_osc;
      w_consume     = 1'b0;
      w_capt        = 1'b0;
      w_wrap        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_pend_valid) begin
               w_voice_nx   = r_pend_voice;
               w_osc_nx     = '0;
               w_cur_pri_nx = 1'b1;
               w_consume    = 1'b1;
               w_cnt_nx     = C_LOAD;
               w_state_nx   = S_SETTLE;
            end else if (enable) begin
               w_voice_nx   = r_bg_voice;
               w_osc_nx     = r_bg_osc;
               w_cur_pri_nx = 1'b0;
               w_cnt_nx     = C_LOAD;
               w_state_nx   = S_SETTLE;
            end
         end
         S_SETTLE: begin
            // a parameter write invalidates whatever is in flight, so the slot starts over
            if (cfg_write)          w_cnt_nx   = C_LOAD;
            else if (r_cnt == '0)   w_state_nx = S_CAPT;
            else                    w_cnt_nx   = r_cnt - 1'b1;
         end
         S_CAPT: begin
            w_capt     = 1'b1;
            w_cnt_nx   = C_LOAD;
            w_state_nx = S_SETTLE;
            if (!r_cur_pri) begin
               if (r_bg_osc == O_LAST) begin
                  w_bg_osc_nx = '0;
                  if (r_bg_voice == V_LAST) begin
                     w_bg_voice_nx = '0;
                     w_wrap        = 1'b1;
                  end else begin
                     w_bg_voice_nx = r_bg_voice + 1'b1;
                  end
               end else begin
                  w_bg_osc_nx = r_bg_osc + 1'b1;
               end
            end
            // re-request of the voice in progress restarts it; otherwise finish it first
            if (r_pend_valid && r_cur_pri && (r_pend_voice == r_voice)) begin
               w_osc_nx  = '0;
               w_consume = 1'b1;
            end else if (r_cur_pri && (r_osc != O_LAST)) begin
               w_osc_nx = r_osc + 1'b1;
            end else if (r_pend_valid) begin
               w_voice_nx   = r_pend_voice;
               w_osc_nx     = '0;
               w_cur_pri_nx = 1'b1;
               w_consume    = 1'b1;
            end else if (enable) begin
               w_voice_nx   = w_bg_voice_nx;
               w_osc_nx     = w_bg_osc_nx;
               w_cur_pri_nx = 1'b0;
            end else begin
               w_state_nx = S_IDLE;
            end
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge const_clk or posedge reset) begin
      if (reset) begin
         r_cnt        <= '0;
         r_voice      <= '0;
         r_osc        <= '0;
         r_cur_pri    <= 1'b0;
         r_bg_voice   <= '0;
         r_bg_osc     <= '0;
         r_pend_valid <= 1'b0;
         r_pend_voice <= '0;
         r_scan_done  <= 1'b0;
         r_req_drop   <= 1'b0;
      end else begin
         r_cnt       <= w_cnt_nx;
         r_voice     <= w_voice_nx;
         r_osc       <= w_osc_nx;
         r_cur_pri   <= w_cur_pri_nx;
         r_bg_voice  <= w_bg_voice_nx;
         r_bg_osc    <= w_bg_osc_nx;
         r_scan_done <= w_wrap;
         r_req_drop  <= 1'b0;
         if (note_req) begin
            r_pend_valid <= 1'b1;
            r_pend_voice <= note_voice;
            r_req_drop   <= r_pend_valid && !w_consume;
         end else if (w_consume) begin
            r_pend_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge const_clk or posedge reset) begin
      if (reset) begin
         for (int unsigned v = 0; v < VOICES; v++)
            for (int unsigned o = 0; o < V_OSC; o++)
               r_table[v][o] <= '0;
      end else if (w_capt) begin
         r_table[r_voice][r_osc] <= pitch_in;
      end
   end

   assign xxxx      = {r_voice, r_osc, {OE_WIDTH{1'b0}}};
   assign rd_pitch  = r_table[rd_voice][rd_osc];
   assign busy      = (r_state != S_IDLE);
   assign scan_done = r_scan_done;
   assign req_drop  = r_req_drop;

endmodule
